// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: core stores feed a byte FIFO drained by
// a bit-serial shifter; STATUS is read combinationally for single-cycle loads.
`timescale 1ns/1ps

module mmio_uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int              AW          = $clog2(FIFO_DEPTH);
  localparam int              CW          = AW + 1;
  localparam logic [15:0]     BAUD_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [CW-1:0]   DEPTH_C     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          ovf;

  state_t        state, state_n;
  logic [15:0]   baud, baud_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;

  logic full, empty, pop, push_req, push_ok, clr_ovf, tx_active;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign push_req  = sel & we & ~addr;
  assign push_ok   = push_req & (~full | pop);
  assign clr_ovf   = sel & we & addr & wdata[3];
  assign tx_active = (state != IDLE);
  assign busy      = tx_active | ~empty;

  // NOTE: storage has no reset; only entries covered by count are ever read,
  // so clearing it would cost a reset net per bit for nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata[7:0];
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (pop && !push_ok) count <= count - CW'(1);
      if (push_req && !push_ok) ovf <= 1'b1;
      else if (clr_ovf)         ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no latches.
  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rptr];
          baud_n  = BAUD_RELOAD;
          state_n = START;
        end
      end
      START: begin
        if (baud == '0) begin
          state_n   = DATA;
          bit_idx_n = '0;
          baud_n    = BAUD_RELOAD;
        end else begin
          baud_n = baud - 16'd1;
        end
      end
      DATA: begin
        if (baud == '0) begin
          baud_n = BAUD_RELOAD;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shift_n   = {1'b0, shift[7:1]};
          end
        end else begin
          baud_n = baud - 16'd1;
        end
      end
      STOP: begin
        if (baud == '0) begin
          // Chain straight into the next start bit when more bytes wait.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rptr];
            baud_n  = BAUD_RELOAD;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      default: tx = 1'b1;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (sel && addr) begin
      rdata[0]       = tx_active;
      rdata[1]       = full;
      rdata[2]       = empty;
      rdata[3]       = ovf;
      rdata[4 +: CW] = count;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx (CLK_DIV=4, FIFO_DEPTH=4): frame timing,
// back-to-back chaining, overflow, pointer wrap and asynchronous reset abort.
`timescale 1ns/1ps

module tb_mmio_uart_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel   = 1'b0;
  logic        we    = 1'b0;
  logic        addr  = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [9:0] frames [$];

  always #5 clk = ~clk;

  mmio_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .tx(tx), .busy(busy)
  );

  // Line monitor: samples each frame mid-bit; element [0] is the start bit.
  initial begin : monitor
    logic [9:0] line;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (2) @(negedge clk);
        line[0] = tx;
        for (int b = 1; b < 10; b++) begin
          repeat (4) @(negedge clk);
          line[b] = tx;
        end
        frames.push_back(line);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // All tasks start and end 1 ns after a rising edge.
  task automatic write_reg(input logic a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; addr = 1'b0; wdata = '0;
  endtask

  task automatic read_status(output logic [31:0] v);
    sel = 1'b1; we = 1'b0; addr = 1'b1;
    #1 v = rdata;
    sel = 1'b0; addr = 1'b0;
  endtask

  // Called at the edge where the start bit began; ends 38 cycles later.
  task automatic capture_frame(output logic [9:0] line);
    repeat (2) @(posedge clk);
    #1 line[0] = tx;
    for (int b = 1; b < 10; b++) begin
      repeat (4) @(posedge clk);
      #1 line[b] = tx;
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (frames.size() < n && c < budget) begin
      @(posedge clk); c++;
    end
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy !== 1'b0 && c < budget) begin
      @(posedge clk); c++;
    end
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    read_status(v);
    checks++; if (v !== 32'h4) begin errors++; $display("FAIL reset_status: got %h expected 00000004", v); end
    sel = 1'b0; addr = 1'b1; #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rdata_unselected: got %h expected 0", rdata); end
    sel = 1'b1; addr = 1'b0; #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rdata_data_reg: got %h expected 0", rdata); end
    sel = 1'b0; we = 1'b1; addr = 1'b0; wdata = 32'hFF;
    @(posedge clk); #1;
    we = 1'b0; wdata = '0;
    read_status(v);
    checks++; if (v !== 32'h4) begin errors++; $display("FAIL unselected_store: got %h expected 00000004", v); end
  endtask

  task automatic test_single_frame;
    logic [9:0] line;
    write_reg(1'b0, 32'hA5);
    checks++; if (tx !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL a5_after_push: got tx=%b busy=%b expected tx=1 busy=1", tx, busy); end
    @(posedge clk); #1;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL a5_start_latency: got %b expected 0", tx); end
    capture_frame(line);
    checks++; if (line !== 10'b1101001010) begin errors++; $display("FAIL a5_frame: got %b expected 1101001010", line); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL a5_last_stop_cycle: got busy=%b expected 1", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL a5_frame_end: got busy=%b tx=%b expected busy=0 tx=1", busy, tx); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] line;
    write_reg(1'b0, 32'h41);
    write_reg(1'b0, 32'h42);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_first_start: got %b expected 0", tx); end
    capture_frame(line);
    checks++; if (line !== 10'b1010000010) begin errors++; $display("FAIL b2b_frame_41: got %b expected 1010000010", line); end
    @(posedge clk); #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL b2b_stop: got %b expected 1", tx); end
    @(posedge clk); #1;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_no_gap: got %b expected 0", tx); end
    capture_frame(line);
    checks++; if (line !== 10'b1010000100) begin errors++; $display("FAIL b2b_frame_42: got %b expected 1010000100", line); end
    repeat (2) @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_80_cycles: got busy=%b expected 0", busy); end
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    logic [9:0]  exp, got;
    frames.delete();
    for (int i = 0; i < 6; i++) write_reg(1'b0, 32'h10 + 32'(i));
    read_status(v);
    checks++; if (v !== 32'h4B) begin errors++; $display("FAIL ovf_status: got %h expected 0000004b", v); end
    write_reg(1'b1, 32'h8);
    read_status(v);
    checks++; if (v !== 32'h43) begin errors++; $display("FAIL ovf_clear: got %h expected 00000043", v); end
    wait_frames(5, 400);
    wait_idle(200);
    repeat (50) @(posedge clk); #1;
    checks++; if (frames.size() != 5) begin errors++; $display("FAIL ovf_frame_count: got %0d expected 5", frames.size()); end
    for (int i = 0; i < 5; i++) begin
      exp = {1'b1, 8'h10 + 8'(i), 1'b0};
      got = (i < frames.size()) ? frames[i] : 10'bx;
      checks++; if (got !== exp) begin errors++; $display("FAIL ovf_frame_%0d: got %b expected %b", i, got, exp); end
    end
    read_status(v);
    checks++; if (v !== 32'h4) begin errors++; $display("FAIL ovf_drained_status: got %h expected 00000004", v); end
  endtask

  task automatic test_wrap;
    logic [31:0] v;
    logic [9:0]  exp, got;
    frames.delete();
    for (int i = 0; i < 5; i++) write_reg(1'b0, 32'h60 + 32'(i));
    repeat (36) @(posedge clk); #1;
    read_status(v);
    checks++; if (v !== 32'h43) begin errors++; $display("FAIL wrap_full_before: got %h expected 00000043", v); end
    write_reg(1'b0, 32'h65);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL wrap_chain_start: got %b expected 0", tx); end
    read_status(v);
    checks++; if (v !== 32'h43) begin errors++; $display("FAIL wrap_push_on_pop: got %h expected 00000043", v); end
    wait_frames(6, 500);
    wait_idle(200);
    checks++; if (frames.size() != 6) begin errors++; $display("FAIL wrap_frame_count: got %0d expected 6", frames.size()); end
    for (int i = 0; i < 6; i++) begin
      exp = {1'b1, 8'h60 + 8'(i), 1'b0};
      got = (i < frames.size()) ? frames[i] : 10'bx;
      checks++; if (got !== exp) begin errors++; $display("FAIL wrap_frame_%0d: got %b expected %b", i, got, exp); end
    end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] v;
    logic [9:0]  line;
    int          lows;
    write_reg(1'b0, 32'h30);
    write_reg(1'b0, 32'h31);
    write_reg(1'b0, 32'h32);
    repeat (16) @(posedge clk); #2;
    checks++; if (tx !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rst_pre_bit3: got tx=%b busy=%b expected tx=0 busy=1", tx, busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_async: got tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
    @(posedge clk); #1 rst_n = 1'b1;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL rst_no_tx_after: got %0d low samples expected 0", lows); end
    @(posedge clk); #1;
    read_status(v);
    checks++; if (v !== 32'h4) begin errors++; $display("FAIL rst_status_after: got %h expected 00000004", v); end
    frames.delete();
    write_reg(1'b0, 32'h5A);
    @(posedge clk); #1;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rst_new_start: got %b expected 0", tx); end
    capture_frame(line);
    checks++; if (line !== 10'b1010110100) begin errors++; $display("FAIL rst_new_frame: got %b expected 1010110100", line); end
    repeat (2) @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_new_end: got busy=%b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_wrap();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter sitting on the single-cycle RISC-V core's data-memory bus, downstream of the core's store path. Bytes written by core stores are buffered in a small FIFO and serialized as 8N1 frames on `tx`. Status is read back combinationally for the core's single-cycle loads. The top-level bench also samples `tx`, giving program output during simulation.

## Interface
- `CLK_DIV`, default 16: clock cycles per bit; legal range 2..65535.
- `FIFO_DEPTH`, default 8: byte entries; power of two, 2..16.
- `clk`  in  1: system clock, rising-edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `sel`  in  1: peripheral selected by the core's address decode.
- `we`  in  1: store strobe; acts only when `sel`=1.
- `addr`  in  1: register select; 0 = DATA, 1 = STATUS (core address bit 2).
- `wdata`  in  32: store data.
- `rdata`  out  32: combinational read data.
- `tx`  out  1: serial line, idle high.
- `busy`  out  1: high while a frame is shifting or the FIFO is non-empty.

## Operation
- DATA write (`sel&we&addr==0`): push `wdata[7:0]`. The push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
- A push that is not accepted drops the byte and sets sticky `ovf`.
- STATUS write (`addr==1`): `wdata[3]`=1 clears `ovf`. Other bits are ignored.
- A write that sets `ovf` and a clear in the same cycle cannot coincide, because there is a single port.
- `rdata` when `sel`=1 and `addr`=1:
  - bit0 = tx_active (FSM not IDLE)
  - bit1 = full
  - bit2 = empty
  - bit3 = ovf
  - bits[8:4] = count
  - all other bits 0
- `rdata` is 0 when `sel`=0 or `addr`=0, so DATA is write-only.
- Transmit FSM states:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0], held CLK_DIV cycles per bit, LSB first. After bit 7 go to STOP.
  - STOP: `tx`=1 for CLK_DIV cycles.
- End of STOP: if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Baud counter: loaded with CLK_DIV-1 on entry to each bit and decremented each cycle. The bit ends when the counter is 0.
- FIFO:
  - Circular buffer with read and write pointers of log2(FIFO_DEPTH) bits that wrap modulo the depth.
  - The count register is log2(FIFO_DEPTH)+1 bits wide.
  - full = (count==FIFO_DEPTH); empty = (count==0).
  - Simultaneous push and pop: count unchanged, both pointers advance.
- `busy` = tx_active | ~empty.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `rdata`=0 when `sel`=0.
  - FSM=IDLE, count=0, pointers=0, `ovf`=0, baud counter=0, shift register=0.
- Reset asserted mid-frame:
  - `tx` goes to 1 immediately (asynchronous).
  - FIFO contents are discarded and the frame is aborted.
- Write latency:
  - A byte written at edge N is in the FIFO after N.
  - If the FSM is IDLE, it pops at edge N+1 and `tx` falls after edge N+1.
- Frame length: exactly 10*CLK_DIV cycles, from the `tx` falling edge to the end of STOP.
- Back-to-back bytes in the FIFO: the next start bit begins on the cycle after the last STOP cycle.
- STATUS reflects register state after the most recent edge. A store and a load in the same cycle are impossible.
- A pop in IDLE and a push of a new byte in the same cycle are both performed.

## Test plan
- Reset with `rst_n` low for 3 cycles, then release -> `tx`=1, `busy`=0, STATUS read = 0x0000_0004 (empty only).
- CLK_DIV=4, write 0xA5 -> `tx` falls 1 cycle after the write edge; sampled mid-bit, the line reads 0,1,0,1,0,0,1,0,1,1 over 40 cycles; then `busy`=0.
- CLK_DIV=4, write 0x41 then 0x42 on consecutive cycles -> two frames totalling 80 cycles with no idle cycle between the first STOP and the second START.
- FIFO_DEPTH=4, CLK_DIV=4, write 6 bytes on consecutive cycles:
  - The first byte is popped at the second edge, so 5 bytes are accepted and 1 is dropped.
  - STATUS shows full=1, count=4, ovf=1.
  - Writing STATUS with 0x8 clears ovf.
  - All 5 accepted bytes appear on `tx` in order.
- Fill the FIFO, then push exactly on the cycle the FSM pops at the end of STOP -> the push is accepted, count stays 4, ovf stays 0, and the pointer wrap-around keeps the output order correct.
- Assert `rst_n` low for 1 cycle during DATA bit 3 with 2 bytes queued -> `tx`=1 immediately and nothing is transmitted afterward. After release: STATUS=0x4, and a new write produces a clean frame.
